axi_lite_mem_slave: RTL and testbench
=====================================

Name: axi_lite_mem_slave

Overview:
- AXI4-Lite responder: a word-addressed block-RAM data memory that serves the core's load/store bus.
- Sits on the far end of the core's axi_* master ports, which use the same port names with opposite directions.
- Independent read and write channel FSMs share one single-port RAM.
- Honours byte strobes, returns OKAY/SLVERR responses, and holds every response until it is accepted.

Parameters:
- ADDR_WIDTH, 12, word-address bits. Depth is 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- axi_awaddr  in  32  write byte address.
- axi_awvalid  in  1  write address valid.
- axi_awready  out  1  write address ready.
- axi_awprot  in  3  ignored.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- axi_wvalid  in  1  write data valid.
- axi_wready  out  1  write data ready.
- axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- axi_bvalid  out  1  write response valid.
- axi_bready  in  1  write response ready.
- axi_araddr  in  32  read byte address.
- axi_arvalid  in  1  read address valid.
- axi_arready  out  1  read address ready.
- axi_arprot  in  3  ignored.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  read response.
- axi_rvalid  out  1  read data valid.
- axi_rready  in  1  read data ready.

Behaviour:
- Reset: every output is 0. The cycle after rst deasserts, awready, wready and arready go to 1. RAM contents are not cleared.
- All outputs are registered.
- Word index = (addr - BASE_ADDR)[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
- In range means BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_WIDTH.
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - W_IDLE: AW is captured on awvalid && awready, then awready drops next cycle. W is captured on wvalid && wready, then wready drops next cycle.
  - AW and W may arrive in either order or in the same cycle. Once both are captured, go to W_EXEC.
  - W_EXEC: write the strobed bytes if in range; if out of range, do not write and latch SLVERR. Then go to W_RESP.
  - W_RESP: bvalid = 1 with bresp held stable until bready. On the bvalid && bready cycle, clear bvalid, set awready and wready to 1, and return to W_IDLE.
  - wstrb = 4'b0000 writes nothing and responds OKAY.
- Read FSM states: R_IDLE, R_READ, R_RESP.
  - R_IDLE: arready = 1. On the AR handshake, latch the address, drop arready, and go to R_READ.
  - R_READ: one RAM read cycle. Go to R_RESP with rdata = RAM word and rresp = OKAY; if out of range, rdata = 0 and rresp = SLVERR.
  - R_RESP: rvalid = 1 with rdata and rresp held until rready. On the handshake, clear rvalid, set arready to 1, and go to R_IDLE.
- Latency with no contention: handshake cycle T, RAM access at T+1, bvalid/rvalid high at T+2. This is 2 cycles minimum, from the later of the AW/W handshakes for writes.
- RAM arbitration: if W_EXEC and R_READ occur in the same cycle, the write performs and the read stalls one cycle in R_READ. The read therefore returns post-write data, even for the same word.
- Throughput: at most one outstanding transaction per channel, with no pipelining; a new address is not accepted until the response handshake completes.
- Backpressure: bvalid and rvalid never drop without a handshake. No combinational path exists from any input to any output.
- rst mid-transaction: all FSMs return to IDLE and outputs return to reset values on the next edge. Pending transactions are dropped; any RAM write already performed stays.

Test Plan:
- Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF with AW and W in the same cycle, bready=1 → bvalid at T+2 with bresp=00. Then read 0x10 → rvalid at T+2 with rdata=0xDEADBEEF, rresp=00.
- Byte strobe: after the first scenario, write 0x10 with wdata=0x00AA0000 and wstrb=4'b0100 → reading 0x10 returns 0xDEAABEEF. Reading address 0x13 returns the same word.
- W presented 3 cycles before AW → wready drops after its handshake and awready stays 1. bvalid rises 2 cycles after the AW handshake. Hold bready=0 for 5 cycles → bvalid and bresp stay stable, and arready remains unaffected.
- Out of range with ADDR_WIDTH=12: write 0x4000 → bresp=10 and memory is unchanged. Read 0x4000 → rresp=10, rdata=0.
- Contention: write 0x20=0x12345678 and read 0x20 handshaked in the same cycle → the write responds at T+2, the read at T+3 with rdata=0x12345678.
- Reset while rvalid=1 and rready=0 → the next cycle has rvalid=0, and all readies are 1 one cycle after rst deasserts. RAM data written before the reset remains readable.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite responder in front of a word-addressed
// 32-bit block RAM. Independent write (AW/W/B) and read (AR/R) channel FSMs
// share one single-port RAM; the write wins when both want it in one cycle.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   axi_aw* / axi_w* / axi_b* write address, write data, write response channels
//   axi_ar* / axi_r*          read address, read data channels
//   axi_awprot, axi_arprot    accepted and ignored
// All outputs are registered; responses are held until accepted.
module axi_lite_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [31:0] mem [DEPTH];

  // Address decode done at capture time so only index + range flag are held.
  logic [31:0]           aw_off;
  logic [31:0]           ar_off;
  logic                  aw_in_range;
  logic                  ar_in_range;
  logic [ADDR_WIDTH-1:0] aw_idx;
  logic [ADDR_WIDTH-1:0] ar_idx;

  assign aw_off      = axi_awaddr - BASE_ADDR;
  assign ar_off      = axi_araddr - BASE_ADDR;
  assign aw_in_range = {1'b0, aw_off} < SPAN;
  assign ar_in_range = {1'b0, ar_off} < SPAN;
  assign aw_idx      = aw_off[ADDR_WIDTH+1:2];
  assign ar_idx      = ar_off[ADDR_WIDTH+1:2];

  // Prot fields and the non-index address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{axi_awprot, axi_arprot, aw_off, ar_off};

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;

  // Write channel state
  logic                  aw_done;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] w_idx_q;
  logic                  w_in_range_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  // Read channel state
  logic [ADDR_WIDTH-1:0] r_idx_q;
  logic                  r_in_range_q;

  // Write FSM: collect AW and W in any order, one RAM write, hold B until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state      <= W_IDLE;
      axi_awready  <= 1'b0;
      axi_wready   <= 1'b0;
      axi_bvalid   <= 1'b0;
      axi_bresp    <= OKAY;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      w_idx_q      <= '0;
      w_in_range_q <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx_q      <= aw_idx;
            w_in_range_q <= aw_in_range;
            aw_done      <= 1'b1;
            axi_awready  <= 1'b0;
          end else if (!aw_done) begin
            axi_awready  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q    <= axi_wdata;
            wstrb_q    <= axi_wstrb;
            w_done     <= 1'b1;
            axi_wready <= 1'b0;
          end else if (!w_done) begin
            axi_wready <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            w_state <= W_EXEC;
          end
        end
        W_EXEC: begin
          axi_bresp  <= w_in_range_q ? OKAY : SLVERR;
          axi_bvalid <= 1'b1;
          w_state    <= W_RESP;
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            axi_wready  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM write port, byte-strobed; RAM contents are never reset.
  always_ff @(posedge clk) begin
    if (!rst && (w_state == W_EXEC) && w_in_range_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[w_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  // Read FSM: R_READ waits while the write owns the RAM, so reads see post-write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= R_IDLE;
      axi_arready  <= 1'b0;
      axi_rvalid   <= 1'b0;
      axi_rdata    <= '0;
      axi_rresp    <= OKAY;
      r_idx_q      <= '0;
      r_in_range_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx_q      <= ar_idx;
            r_in_range_q <= ar_in_range;
            axi_arready  <= 1'b0;
            r_state      <= R_READ;
          end else begin
            axi_arready  <= 1'b1;
          end
        end
        R_READ: begin
          if (w_state != W_EXEC) begin
            axi_rdata  <= r_in_range_q ? mem[r_idx_q] : 32'h0;
            axi_rresp  <= r_in_range_q ? OKAY : SLVERR;
            axi_rvalid <= 1'b1;
            r_state    <= R_RESP;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            axi_rvalid  <= 1'b0;
            axi_arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: directed scenarios plus
// randomized single transactions checked against an associative-array memory model.
module tb_axi_lite_mem_slave;

  localparam int unsigned AW   = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [2:0]  axi_awprot;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [2:0]  axi_arprot;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;

  axi_lite_mem_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory model: word index -> last written value (only known words stored).
  logic [31:0] mdl [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    return (off >= 0) && (off < (longint'(4) << AW));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Apply AXI byte-strobe semantics to the model.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!in_rng(a)) return;
    w = mdl.exists(widx(a)) ? mdl[widx(a)] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mdl[widx(a)] = w;
  endtask

  // Entered and left at a negedge. Delays are in cycles before valid rises.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, input bit check_ar);
    bit aw_ok = 0, w_ok = 0, awh, wh;
    int c = 0, n;
    logic [1:0] r0;
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    axi_awprot = 3'($urandom);
    while (!(aw_ok && w_ok)) begin
      if (c > 50) begin
        chk("w_hs_timeout", 32'(c), 32'd0);
        axi_awvalid = 0; axi_wvalid = 0;
        return;
      end
      axi_awvalid = !aw_ok && (c >= aw_dly);
      axi_wvalid  = !w_ok && (c >= w_dly);
      awh = axi_awvalid && axi_awready;
      wh  = axi_wvalid && axi_wready;
      @(posedge clk); @(negedge clk);
      c++;
      if (awh) aw_ok = 1;
      if (wh)  w_ok  = 1;
      axi_awvalid = 0; axi_wvalid = 0;
      if (wh && !aw_ok) begin
        chk("wready_drop", 32'(axi_wready), 32'd0);
        chk("awready_hold", 32'(axi_awready), 32'd1);
      end
    end
    n = 1;
    while (!axi_bvalid && n < 20) begin @(negedge clk); n++; end
    chk("b_latency", 32'(n), 32'd2);
    chk("bresp", 32'(axi_bresp), in_rng(addr) ? 32'd0 : 32'd2);
    model_write(addr, data, strb);
    r0 = axi_bresp;
    repeat (b_dly) begin
      @(negedge clk);
      chk("b_hold", 32'(axi_bvalid), 32'd1);
      chk("b_stable", 32'(axi_bresp), 32'(r0));
      if (check_ar) chk("arready_free", 32'(axi_arready), 32'd1);
    end
    axi_bready = 1;
    @(posedge clk); @(negedge clk);
    axi_bready = 0;
    chk("b_clear", 32'(axi_bvalid), 32'd0);
    chk("aw_ready_back", 32'({axi_awready, axi_wready}), 32'd3);
  endtask

  task automatic exp_read(input logic [31:0] addr, output logic [31:0] d,
                          output logic [1:0] r, output bit known);
    known = 1;
    if (!in_rng(addr)) begin d = 0; r = 2'b10; end
    else begin
      r = 2'b00;
      known = mdl.exists(widx(addr));
      d = known ? mdl[widx(addr)] : 32'h0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int c = 0, n;
    bit known;
    logic [31:0] ed;
    logic [1:0] er;
    axi_araddr = addr;
    axi_arprot = 3'($urandom);
    repeat (ar_dly) @(negedge clk);
    axi_arvalid = 1;
    while (!axi_arready) begin
      if (c > 50) begin chk("ar_hs_timeout", 32'(c), 32'd0); axi_arvalid = 0; return; end
      @(negedge clk); c++;
    end
    @(posedge clk); @(negedge clk);
    axi_arvalid = 0;
    chk("arready_drop", 32'(axi_arready), 32'd0);
    n = 1;
    while (!axi_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("r_latency", 32'(n), 32'd2);
    exp_read(addr, ed, er, known);
    chk("rresp", 32'(axi_rresp), 32'(er));
    if (known) chk("rdata", axi_rdata, ed);
    repeat (r_dly) begin
      @(negedge clk);
      chk("r_hold", 32'(axi_rvalid), 32'd1);
      if (known) chk("r_stable", axi_rdata, ed);
    end
    axi_rready = 1;
    @(posedge clk); @(negedge clk);
    axi_rready = 0;
    chk("r_clear", 32'(axi_rvalid), 32'd0);
    chk("arready_back", 32'(axi_arready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, 32'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                  axi_bresp, axi_rresp}), 32'd0);
    chk(tag, axi_rdata, 32'd0);
  endtask

  initial begin
    int b_n, r_n, n;
    logic [31:0] a, d;
    rst = 1;
    axi_awaddr = 0; axi_awvalid = 0; axi_awprot = 0; axi_wdata = 0; axi_wstrb = 0;
    axi_wvalid = 0; axi_bready = 0; axi_araddr = 0; axi_arvalid = 0; axi_arprot = 0;
    axi_rready = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst = 0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_reset", 32'({axi_awready, axi_wready, axi_arready}), 32'd7);

    // Known contents for the region the random phase uses.
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0, 0);

    // Same-cycle AW/W, then read back.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    do_read(32'h10, 0, 0);
    // Single byte lane; unaligned address hits the same word.
    do_write(32'h10, 32'h00AA0000, 4'b0100, 0, 0, 0, 0);
    do_read(32'h10, 0, 0);
    chk("strobe_model", mdl[4], 32'hDEAABEEF);
    do_read(32'h13, 0, 1);
    // W three cycles ahead of AW, B backpressured five cycles.
    do_write(32'h14, 32'hCAFEF00D, 4'hF, 3, 0, 5, 1);
    do_read(32'h14, 1, 0);
    // Empty strobe.
    do_write(32'h14, 32'h11111111, 4'h0, 0, 2, 0, 0);
    do_read(32'h14, 0, 0);
    // Out of range: aliases word 0 by index bits, must not write it.
    do_write(32'h4000, 32'hBADBAD00, 4'hF, 0, 0, 1, 0);
    do_read(32'h4000, 0, 0);
    do_read(32'h0, 0, 0);

    // Contention: AW, W and AR on 0x20 in one cycle.
    axi_awaddr = 32'h20; axi_wdata = 32'h12345678; axi_wstrb = 4'hF; axi_araddr = 32'h20;
    axi_awvalid = 1; axi_wvalid = 1; axi_arvalid = 1;
    chk("idle_readies", 32'({axi_awready, axi_wready, axi_arready}), 32'd7);
    @(posedge clk); @(negedge clk);
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
    model_write(32'h20, 32'h12345678, 4'hF);
    b_n = 0; r_n = 0;
    for (int k = 1; k <= 8; k++) begin
      if (axi_bvalid && b_n == 0) b_n = k;
      if (axi_rvalid && r_n == 0) r_n = k;
      if (k < 8) @(negedge clk);
    end
    chk("cont_b_lat", 32'(b_n), 32'd2);
    chk("cont_r_lat", 32'(r_n), 32'd3);
    chk("cont_rdata", axi_rdata, 32'h12345678);
    chk("cont_rresp", 32'(axi_rresp), 32'd0);
    axi_bready = 1; axi_rready = 1;
    @(posedge clk); @(negedge clk);
    axi_bready = 0; axi_rready = 0;
    chk("cont_clear", 32'({axi_bvalid, axi_rvalid}), 32'd0);

    // Randomized single transactions.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0: a = 32'h4000;
          1: a = 32'hFFFF_FFFC;
          default: a = 32'h4004 + 32'($urandom_range(255));
        endcase
      end else begin
        a = 32'($urandom_range(15) * 4 + $urandom_range(3));
      end
      if ($urandom_range(1) == 0)
        do_write(a, $urandom, 4'($urandom), $urandom_range(3), $urandom_range(3),
                 $urandom_range(3), 1);
      else
        do_read(a, $urandom_range(2), $urandom_range(3));
    end

    // Reset with a read response stalled.
    axi_araddr = 32'h10; axi_arvalid = 1;
    @(posedge clk); @(negedge clk);
    axi_arvalid = 0;
    n = 1;
    while (!axi_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("pre_rst_rvalid", 32'(axi_rvalid), 32'd1);
    rst = 1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("mid_reset_outputs");
    rst = 0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_mid_reset", 32'({axi_awready, axi_wready, axi_arready}), 32'd7);
    do_read(32'h10, 0, 0);
    do_read(32'h20, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
